// File: rtl/vga_sync_gen.sv
// Raster timing generator: advances one pixel per pix_en and produces VGA syncs,
// pixel coordinates, active-video and line/frame start pulses, all registered.
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int CW       = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_en,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_SS     = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SE     = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] V_SS     = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SE     = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  logic [CW-1:0] r_x, r_y;
  logic          r_hsync, r_vsync, r_video_on, r_line_start, r_frame_start;

  logic          w_x_wrap, w_y_wrap;
  logic [CW-1:0] w_x_next, w_y_next;
  logic          w_hsync, w_vsync, w_video_on;

  // Decode from the next count so registered outputs line up with the counters.
  always_comb begin
    w_x_wrap   = (r_x == H_LAST);
    w_y_wrap   = (r_y == V_LAST);
    w_x_next   = w_x_wrap ? '0 : r_x + ONE;
    w_y_next   = r_y;
    if (w_x_wrap) begin
      w_y_next = w_y_wrap ? '0 : r_y + ONE;
    end
    w_hsync    = ((w_x_next >= H_SS) && (w_x_next <= H_SE)) ? SYNC_POL : ~SYNC_POL;
    w_vsync    = ((w_y_next >= V_SS) && (w_y_next <= V_SE)) ? SYNC_POL : ~SYNC_POL;
    w_video_on = (w_x_next < H_ACT) && (w_y_next < V_ACT);
  end

  // Reset parks the raster one pixel before (0,0) so the first pix_en starts a frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_x           <= H_LAST;
      r_y           <= V_LAST;
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_video_on    <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      if (pix_en) begin
        r_x           <= w_x_next;
        r_y           <= w_y_next;
        r_hsync       <= w_hsync;
        r_vsync       <= w_vsync;
        r_video_on    <= w_video_on;
        r_line_start  <= w_x_wrap;
        r_frame_start <= w_x_wrap && w_y_wrap;
      end
    end
  end

  assign pixel_x     = r_x;
  assign pixel_y     = r_y;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign video_on    = r_video_on;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default 640x480 instance for line-level checks and a
// shrunken-timing instance for whole-frame, vsync and mid-sync reset checks.
module tb_vga_sync_gen;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb;
  } tim_t;

  typedef struct {
    int   x, y;
    logic hs, vs, von, ls, fs;
  } st_t;

  localparam tim_t TA = '{640, 16, 96, 48, 480, 10, 2, 33};
  localparam tim_t TB = '{8, 2, 3, 2, 4, 1, 2, 2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b0, en_a = 1'b0;
  logic       rst_b = 1'b0, en_b = 1'b0;
  logic       hs_a, vs_a, von_a, ls_a, fs_a;
  logic       hs_b, vs_b, von_b, ls_b, fs_b;
  logic [9:0] x_a, y_a, x_b, y_b;

  vga_sync_gen u_dut_a (
    .clk(clk), .rst_n(rst_a), .pix_en(en_a),
    .hsync(hs_a), .vsync(vs_a), .video_on(von_a),
    .pixel_x(x_a), .pixel_y(y_a),
    .line_start(ls_a), .frame_start(fs_a)
  );

  vga_sync_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .SYNC_POL(1'b0), .CW(10)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_b), .pix_en(en_b),
    .hsync(hs_b), .vsync(vs_b), .video_on(von_b),
    .pixel_x(x_b), .pixel_y(y_b),
    .line_start(ls_b), .frame_start(fs_b)
  );

  logic [24:0] exp_a[$];
  logic [24:0] exp_b[$];
  int          vectors = 0;
  int          miscompares = 0;
  st_t         ma, mb;
  bit          cnt_on = 1'b0;
  int          fs_cnt = 0, vs_cnt = 0;

  // Reference raster model written against the timing table, not the RTL.
  function automatic st_t model_step(input tim_t t, input st_t s, input logic r, input logic e);
    st_t n;
    int  htot, vtot;
    htot = t.ha + t.hf + t.hs + t.hb;
    vtot = t.va + t.vf + t.vs + t.vb;
    n = s;
    n.ls = 1'b0;
    n.fs = 1'b0;
    if (!r) begin
      n.x = htot - 1; n.y = vtot - 1;
      n.hs = 1'b1; n.vs = 1'b1; n.von = 1'b0;
    end else if (e) begin
      n.x = s.x + 1;
      if (n.x == htot) begin
        n.x = 0;
        n.y = (s.y + 1 == vtot) ? 0 : s.y + 1;
      end
      n.hs  = !((n.x >= t.ha + t.hf) && (n.x < t.ha + t.hf + t.hs));
      n.vs  = !((n.y >= t.va + t.vf) && (n.y < t.va + t.vf + t.vs));
      n.von = (n.x < t.ha) && (n.y < t.va);
      n.ls  = (n.x == 0);
      n.fs  = (n.x == 0) && (n.y == 0);
    end
    return n;
  endfunction

  function automatic logic [24:0] mk(input logic hs, input logic vs, input logic von,
                                     input logic ls, input logic fs, input int x, input int y);
    return {hs, vs, von, ls, fs, 10'(x), 10'(y)};
  endfunction

  function automatic logic [24:0] pack(input st_t s);
    return mk(s.hs, s.vs, s.von, s.ls, s.fs, s.x, s.y);
  endfunction

  // Drive one clk of stimulus; expected value comes from the hand vector or the model.
  task automatic drive(input bit sel, input logic r, input logic e,
                       input bit use_hand, input logic [24:0] hand);
    @(negedge clk);
    if (!sel) begin
      rst_a = r; en_a = e;
      ma = model_step(TA, ma, r, e);
      exp_a.push_back(use_hand ? hand : pack(ma));
    end else begin
      rst_b = r; en_b = e;
      mb = model_step(TB, mb, r, e);
      exp_b.push_back(use_hand ? hand : pack(mb));
    end
  endtask

  task automatic d(input bit sel, input logic r, input logic e);
    drive(sel, r, e, 1'b0, '0);
  endtask

  task automatic dh(input bit sel, input logic r, input logic e, input logic [24:0] hand);
    drive(sel, r, e, 1'b1, hand);
  endtask

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  // Monitor: one output sample per edge for every pushed expectation.
  initial begin
    logic [24:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_a.size() > 0) begin
        e = exp_a.pop_front();
        vectors++;
        if ({hs_a, vs_a, von_a, ls_a, fs_a, x_a, y_a} !== e) begin
          miscompares++;
          $display("FAIL dut_a: got hs%b vs%b von%b ls%b fs%b x%0d y%0d, want hs%b vs%b von%b ls%b fs%b x%0d y%0d",
                   hs_a, vs_a, von_a, ls_a, fs_a, x_a, y_a,
                   e[24], e[23], e[22], e[21], e[20], e[19:10], e[9:0]);
        end
      end
      if (exp_b.size() > 0) begin
        e = exp_b.pop_front();
        vectors++;
        if ({hs_b, vs_b, von_b, ls_b, fs_b, x_b, y_b} !== e) begin
          miscompares++;
          $display("FAIL dut_b: got hs%b vs%b von%b ls%b fs%b x%0d y%0d, want hs%b vs%b von%b ls%b fs%b x%0d y%0d",
                   hs_b, vs_b, von_b, ls_b, fs_b, x_b, y_b,
                   e[24], e[23], e[22], e[21], e[20], e[19:10], e[9:0]);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (cnt_on) begin
        if (fs_b) fs_cnt++;
        if (en_b && !vs_b) vs_cnt++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [24:0] rst_vec_a, rst_vec_b;
    int          pulses;
    rst_vec_a = mk(1, 1, 0, 0, 0, 799, 524);
    rst_vec_b = mk(1, 1, 0, 0, 0, 14, 8);
    ma = '{x: 0, y: 0, hs: 1'b1, vs: 1'b1, von: 1'b0, ls: 1'b0, fs: 1'b0};
    mb = ma;

    // Reset held with pix_en toggling.
    for (int i = 0; i < 3; i++) dh(1'b0, 1'b0, logic'(i % 2), rst_vec_a);

    // Sparse pix_en, one pulse every 4th clk.
    for (int i = 0; i < 3; i++) dh(1'b0, 1'b1, 1'b0, rst_vec_a);
    dh(1'b0, 1'b1, 1'b1, mk(1, 1, 1, 1, 1, 0, 0));
    for (int i = 0; i < 3; i++) dh(1'b0, 1'b1, 1'b0, mk(1, 1, 1, 0, 0, 0, 0));
    dh(1'b0, 1'b1, 1'b1, mk(1, 1, 1, 0, 0, 1, 0));

    // Rest of line 0 back-to-back, with sync/blank edges hand-checked.
    for (int x = 2; x < 800; x++) begin
      case (x)
        639:     dh(1'b0, 1'b1, 1'b1, mk(1, 1, 1, 0, 0, 639, 0));
        640:     dh(1'b0, 1'b1, 1'b1, mk(1, 1, 0, 0, 0, 640, 0));
        655:     dh(1'b0, 1'b1, 1'b1, mk(1, 1, 0, 0, 0, 655, 0));
        656:     dh(1'b0, 1'b1, 1'b1, mk(0, 1, 0, 0, 0, 656, 0));
        751:     dh(1'b0, 1'b1, 1'b1, mk(0, 1, 0, 0, 0, 751, 0));
        752:     dh(1'b0, 1'b1, 1'b1, mk(1, 1, 0, 0, 0, 752, 0));
        799:     dh(1'b0, 1'b1, 1'b1, mk(1, 1, 0, 0, 0, 799, 0));
        default: d(1'b0, 1'b1, 1'b1);
      endcase
    end
    dh(1'b0, 1'b1, 1'b1, mk(1, 1, 1, 1, 0, 0, 1));

    // Stall mid-line: everything frozen, no pulses, then resume.
    for (int x = 1; x < 300; x++) d(1'b0, 1'b1, 1'b1);
    dh(1'b0, 1'b1, 1'b1, mk(1, 1, 1, 0, 0, 300, 1));
    for (int i = 0; i < 50; i++) dh(1'b0, 1'b1, 1'b0, mk(1, 1, 1, 0, 0, 300, 1));
    dh(1'b0, 1'b1, 1'b1, mk(1, 1, 1, 0, 0, 301, 1));
    dh(1'b0, 1'b0, 1'b0, rst_vec_a);

    // Small raster: 15 x 9 = 135 pixels/frame, vsync low on lines 5..6.
    dh(1'b1, 1'b0, 1'b1, rst_vec_b);
    dh(1'b1, 1'b0, 1'b0, rst_vec_b);
    cnt_on = 1'b1;
    pulses = 0;
    while (pulses < 405) begin
      repeat ($urandom_range(0, 2)) d(1'b1, 1'b1, 1'b0);
      d(1'b1, 1'b1, 1'b1);
      pulses++;
    end
    @(posedge clk);
    #2;
    cnt_on = 1'b0;
    check("frame_start_count", fs_cnt, 3);
    check("vsync_low_pixels", vs_cnt, 90);

    // Reset during hsync+vsync at (11,6), then restart from (0,0).
    dh(1'b1, 1'b0, 1'b0, rst_vec_b);
    for (int i = 1; i < 102; i++) d(1'b1, 1'b1, 1'b1);
    dh(1'b1, 1'b1, 1'b1, mk(0, 0, 0, 0, 0, 11, 6));
    dh(1'b1, 1'b0, 1'b1, rst_vec_b);
    dh(1'b1, 1'b1, 1'b1, mk(1, 1, 1, 1, 1, 0, 0));
    dh(1'b1, 1'b1, 1'b1, mk(1, 1, 1, 0, 0, 1, 0));

    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", exp_a.size() + exp_b.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
